li_receiver_shell: RTL and testbench

- Receiver-side endpoint of a latency-insensitive link. It sits after the last pipeline stage of an interconnect and in front of a consuming core.
- Buffers incoming words in a FWFT FIFO and presents them to the core with a valid/ready handshake.
- Generates the upstream feedback signal: credit-return pulses for "credit" mode, or a registered stop for "carloni" mode.

---
 rtl/li_receiver_shell.sv | 158 +++++++++++++++
 tb/tb_li_receiver_shell.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/li_receiver_shell.sv
`default_nettype none
// ============================================================================
// Module   : li_receiver_shell
// Purpose  : Receiver endpoint of a latency-insensitive link. Incoming words
//            are stored in a first-word-fall-through FIFO, handed to the core
//            with a valid/ready handshake, and upstream feedback is generated
//            as credit-return pulses ("credit") or a registered stop signal
//            ("carloni").
// Options  : LI_RX_OVERFLOW_DETECT_EN - when defined, a sticky o_overflow flag
//            records words dropped because the FIFO was full. When undefined,
//            o_overflow is tied low and no detection logic exists.
// Revision : 1.0 - initial release
// ============================================================================
module li_receiver_shell #(
   parameter int    DATA_WIDTH        = 32,
   parameter string INTERCONNECT_TYPE = "credit",
   parameter int    FIFO_DEPTH        = 8,
   parameter int    STOP_MARGIN       = 2
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic signed [DATA_WIDTH-1:0]  i_data,
   input  logic                          i_valid,
   output logic                          o_li_feedback,
   output logic signed [DATA_WIDTH-1:0]  o_data,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic [$clog2(FIFO_DEPTH):0]   o_count,
   output logic                          o_overflow
);

   localparam int          AW           = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] c_DEPTH      = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] c_CNT_ONE    = (AW+1)'(1);
   localparam logic [AW-1:0] c_PTR_ONE  = (AW)'(1);
   localparam bit          c_IS_CREDIT  = (INTERCONNECT_TYPE == "credit");
   localparam bit          c_IS_CARLONI = (INTERCONNECT_TYPE == "carloni");

   // Reject configurations the link protocol cannot work with.
   generate
      if (!c_IS_CREDIT && !c_IS_CARLONI) begin : g_bad_type
         $error("li_receiver_shell: INTERCONNECT_TYPE must be credit or carloni");
      end
      if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
         $error("li_receiver_shell: FIFO_DEPTH must be a power of 2, at least 2");
      end
      if (c_IS_CARLONI && (STOP_MARGIN < 1 || STOP_MARGIN >= FIFO_DEPTH)) begin : g_bad_margin
         $error("li_receiver_shell: STOP_MARGIN must be positive and below FIFO_DEPTH");
      end
   endgenerate

   logic signed [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]                r_wr_ptr;
   logic [AW-1:0]                r_rd_ptr;
   logic [AW:0]                  r_count;
   logic [AW:0]                  w_count_next;
   logic                         w_full;
   logic                         w_pop;
   logic                         w_push;
   logic                         r_feedback;

   // A push is accepted when full only if a pop frees a slot on the same edge.
   assign w_full  = (r_count == c_DEPTH);
   assign o_valid = (r_count != '0);
   assign w_pop   = o_valid & i_ready;
   assign w_push  = i_valid & (~w_full | w_pop);

   // Occupancy after the current edge; shared by the counter and carloni stop.
   always_comb begin
      w_count_next = r_count;
      if (w_push && !w_pop) begin
         w_count_next = r_count + c_CNT_ONE;
      end else if (w_pop && !w_push) begin
         w_count_next = r_count - c_CNT_ONE;
      end
   end

   // Storage array: written on accepted pushes only, contents need no reset.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
         r_count <= w_count_next;
      end
   end

   // Head of FIFO is always visible; it is only meaningful while o_valid=1.
   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;

   generate
      if (c_IS_CARLONI) begin : g_carloni
         localparam logic [AW:0] c_STOP_THRESH = (AW+1)'(FIFO_DEPTH - STOP_MARGIN);
         // Stop upstream while the post-edge occupancy is at or above threshold.
         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               r_feedback <= 1'b0;
            end else begin
               r_feedback <= (w_count_next >= c_STOP_THRESH);
            end
         end
      end else begin : g_credit
         // Return one credit, one cycle after each word leaves the FIFO.
         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               r_feedback <= 1'b0;
            end else begin
               r_feedback <= w_pop;
            end
         end
      end
   endgenerate

   assign o_li_feedback = r_feedback;

`ifdef LI_RX_OVERFLOW_DETECT_EN
   logic w_drop;
   logic r_overflow;

   // A word arriving while full without a simultaneous pop is discarded.
   assign w_drop = i_valid & w_full & ~w_pop;

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end
   end

   assign o_overflow = r_overflow;

`ifndef SYNTHESIS
   a_no_drop : assert property (@(posedge clock) disable iff (!reset) !w_drop)
      else $warning("li_receiver_shell: word dropped, upstream sent into a full buffer");
`endif
`else
   assign o_overflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_li_receiver_shell.sv
`default_nettype none
// ============================================================================
// Module   : tb_li_receiver_shell
// Purpose  : Self-checking bench for li_receiver_shell. A credit instance and
//            a carloni instance (STOP_MARGIN=3) share the same stimulus and are
//            compared against queue-based reference models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_li_receiver_shell;

   localparam int DEPTH  = 8;
   localparam int THRESH = DEPTH - 3;
`ifdef LI_RX_OVERFLOW_DETECT_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] i_data = '0;
   logic        i_valid = 1'b0;
   logic        i_ready = 1'b0;

   logic [31:0] a_data, b_data;
   logic        a_valid, b_valid, a_fb, b_fb, a_ovf, b_ovf;
   logic [3:0]  a_count, b_count;

   logic [31:0] qa[$];
   logic [31:0] qb[$];
   bit          exp_fb_a, exp_fb_b, exp_ovf_a, exp_ovf_b;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   li_receiver_shell #(.DATA_WIDTH(32), .INTERCONNECT_TYPE("credit"),
                       .FIFO_DEPTH(DEPTH), .STOP_MARGIN(2)) u_credit (
      .clock(clk), .reset(rst_n), .i_data(i_data), .i_valid(i_valid),
      .o_li_feedback(a_fb), .o_data(a_data), .o_valid(a_valid),
      .i_ready(i_ready), .o_count(a_count), .o_overflow(a_ovf));

   li_receiver_shell #(.DATA_WIDTH(32), .INTERCONNECT_TYPE("carloni"),
                       .FIFO_DEPTH(DEPTH), .STOP_MARGIN(3)) u_carloni (
      .clock(clk), .reset(rst_n), .i_data(i_data), .i_valid(i_valid),
      .o_li_feedback(b_fb), .o_data(b_data), .o_valid(b_valid),
      .i_ready(i_ready), .o_count(b_count), .o_overflow(b_ovf));

   // One clock of stimulus; models advance by the FIFO rules, not the RTL.
   task automatic cycle(input bit v, input logic [31:0] d, input bit rdy);
      bit pop_a, push_a, pop_b, push_b;
      i_valid = v; i_data = d; i_ready = rdy;
      pop_a  = (qa.size() != 0) && rdy;
      push_a = v && ((qa.size() < DEPTH) || pop_a);
      pop_b  = (qb.size() != 0) && rdy;
      push_b = v && ((qb.size() < DEPTH) || pop_b);
      @(posedge clk); #1;
      if (pop_a) void'(qa.pop_front());
      if (push_a) qa.push_back(d);
      if (pop_b) void'(qb.pop_front());
      if (push_b) qb.push_back(d);
      exp_fb_a = pop_a;
      exp_fb_b = (qb.size() >= THRESH);
      if (v && !push_a) exp_ovf_a = exp_ovf_a | OVF_EN;
      if (v && !push_b) exp_ovf_b = exp_ovf_b | OVF_EN;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_data = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      qa.delete(); qb.delete();
      exp_fb_a = 0; exp_fb_b = 0; exp_ovf_a = 0; exp_ovf_b = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; i_valid = 1'b1; i_data = 32'hDEAD_BEEF; i_ready = 1'b1;
      repeat (2) @(posedge clk); #1;
      checks++; if ({a_valid, a_count, a_fb, a_ovf} !== 7'b0) begin failures++;
         $display("FAIL reset_credit actual={v,cnt,fb,ovf}=%b required=0", {a_valid, a_count, a_fb, a_ovf}); end
      checks++; if ({b_valid, b_count, b_fb, b_ovf} !== 7'b0) begin failures++;
         $display("FAIL reset_carloni actual={v,cnt,fb,ovf}=%b required=0", {b_valid, b_count, b_fb, b_ovf}); end
      do_reset();
   endtask

   task automatic test_fill_drain();
      do_reset();
      for (int i = 0; i < 8; i++) cycle(1, 32'h11 + i, 0);
      checks++; if (a_count !== 4'd8 || a_valid !== 1'b1) begin failures++;
         $display("FAIL fill_count actual cnt=%0d v=%b required cnt=8 v=1", a_count, a_valid); end
      checks++; if (a_data !== 32'h11) begin failures++;
         $display("FAIL fill_head actual=%h required=00000011", a_data); end
      for (int i = 0; i < 8; i++) begin
         checks++; if (a_data !== 32'h11 + i) begin failures++;
            $display("FAIL drain_data[%0d] actual=%h required=%h", i, a_data, 32'h11 + i); end
         cycle(0, 0, 1);
         checks++; if (a_fb !== 1'b1) begin failures++;
            $display("FAIL drain_credit[%0d] actual=%b required=1", i, a_fb); end
      end
      checks++; if (a_count !== 4'd0 || a_valid !== 1'b0) begin failures++;
         $display("FAIL drain_empty actual cnt=%0d v=%b required cnt=0 v=0", a_count, a_valid); end
      cycle(0, 0, 1);
      checks++; if (a_fb !== 1'b0) begin failures++;
         $display("FAIL credit_after_drain actual=%b required=0", a_fb); end
   endtask

   task automatic test_empty_single();
      do_reset();
      i_valid = 1'b1; i_data = 32'h5A; i_ready = 1'b0;
      #2;
      checks++; if (a_valid !== 1'b0) begin failures++;
         $display("FAIL no_bypass actual=%b required=0", a_valid); end
      cycle(1, 32'h5A, 0);
      checks++; if (a_valid !== 1'b1 || a_data !== 32'h5A) begin failures++;
         $display("FAIL single_push actual v=%b d=%h required v=1 d=0000005a", a_valid, a_data); end
      checks++; if (a_fb !== 1'b0) begin failures++;
         $display("FAIL single_no_early_credit actual=%b required=0", a_fb); end
      cycle(0, 0, 1);
      checks++; if (a_fb !== 1'b1 || a_valid !== 1'b0) begin failures++;
         $display("FAIL single_pop actual fb=%b v=%b required fb=1 v=0", a_fb, a_valid); end
      cycle(0, 0, 1);
      checks++; if (a_fb !== 1'b0) begin failures++;
         $display("FAIL single_credit_width actual=%b required=0", a_fb); end
   endtask

   task automatic test_full_push_pop();
      do_reset();
      for (int i = 0; i < 8; i++) cycle(1, 32'h21 + i, 0);
      cycle(1, 32'h99, 1);
      checks++; if (a_count !== 4'd8 || a_ovf !== 1'b0) begin failures++;
         $display("FAIL full_pushpop actual cnt=%0d ovf=%b required cnt=8 ovf=0", a_count, a_ovf); end
      for (int i = 0; i < 8; i++) begin
         logic [31:0] exp;
         exp = (i < 7) ? 32'h22 + i : 32'h99;
         checks++; if (a_data !== exp) begin failures++;
            $display("FAIL full_pushpop_order[%0d] actual=%h required=%h", i, a_data, exp); end
         cycle(0, 0, 1);
      end
      checks++; if (a_count !== 4'd0) begin failures++;
         $display("FAIL full_pushpop_empty actual=%0d required=0", a_count); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 8; i++) cycle(1, 32'h31 + i, 0);
      cycle(1, 32'h77, 0);
      checks++; if (a_count !== 4'd8 || a_data !== 32'h31) begin failures++;
         $display("FAIL overflow_keep actual cnt=%0d d=%h required cnt=8 d=00000031", a_count, a_data); end
      checks++; if (a_ovf !== OVF_EN) begin failures++;
         $display("FAIL overflow_flag actual=%b required=%b", a_ovf, OVF_EN); end
      cycle(0, 0, 0);
      checks++; if (a_ovf !== OVF_EN) begin failures++;
         $display("FAIL overflow_sticky actual=%b required=%b", a_ovf, OVF_EN); end
      for (int i = 0; i < 8; i++) begin
         checks++; if (a_data !== 32'h31 + i) begin failures++;
            $display("FAIL overflow_drain[%0d] actual=%h required=%h", i, a_data, 32'h31 + i); end
         cycle(0, 0, 1);
      end
      checks++; if (a_valid !== 1'b0 || a_ovf !== OVF_EN) begin failures++;
         $display("FAIL overflow_end actual v=%b ovf=%b required v=0 ovf=%b", a_valid, a_ovf, OVF_EN); end
   endtask

   task automatic test_carloni();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         cycle(1, i, 0);
         if (i == 3) begin
            checks++; if (b_fb !== 1'b0) begin failures++;
               $display("FAIL stop_below_thresh actual=%b required=0", b_fb); end
         end
      end
      checks++; if (b_fb !== 1'b1 || b_count !== 4'd5) begin failures++;
         $display("FAIL stop_at_thresh actual fb=%b cnt=%0d required fb=1 cnt=5", b_fb, b_count); end
      cycle(0, 0, 1);
      checks++; if (b_fb !== 1'b0 || b_count !== 4'd4) begin failures++;
         $display("FAIL stop_release actual fb=%b cnt=%0d required fb=0 cnt=4", b_fb, b_count); end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1, 32'h40 + i, 0);
      cycle(1, 32'h45, 1);
      #3 rst_n = 1'b0;
      #1;
      checks++; if ({a_valid, a_count, a_fb, a_ovf} !== 7'b0) begin failures++;
         $display("FAIL async_reset_credit actual={v,cnt,fb,ovf}=%b required=0", {a_valid, a_count, a_fb, a_ovf}); end
      checks++; if ({b_valid, b_count, b_fb, b_ovf} !== 7'b0) begin failures++;
         $display("FAIL async_reset_carloni actual={v,cnt,fb,ovf}=%b required=0", {b_valid, b_count, b_fb, b_ovf}); end
      do_reset();
      cycle(1, 32'h01, 0);
      checks++; if (a_data !== 32'h01 || a_count !== 4'd1) begin failures++;
         $display("FAIL post_reset_push actual d=%h cnt=%0d required d=00000001 cnt=1", a_data, a_count); end
      cycle(0, 0, 1);
      cycle(0, 0, 1);
      checks++; if (a_valid !== 1'b0 || a_fb !== 1'b0) begin failures++;
         $display("FAIL post_reset_stale actual v=%b fb=%b required v=0 fb=0", a_valid, a_fb); end
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 600; n++) begin
         int rdy_pct;
         rdy_pct = ((n / 100) % 2 == 0) ? 25 : 75;
         cycle($urandom_range(99) < 70, $urandom, $urandom_range(99) < rdy_pct);
         checks++; if (a_count !== 4'(qa.size()) || a_valid !== (qa.size() != 0)) begin failures++;
            $display("FAIL rand_credit_count[%0d] actual=%0d required=%0d", n, a_count, qa.size()); end
         if (qa.size() != 0) begin
            checks++; if (a_data !== qa[0]) begin failures++;
               $display("FAIL rand_credit_data[%0d] actual=%h required=%h", n, a_data, qa[0]); end
         end
         checks++; if (a_fb !== exp_fb_a || a_ovf !== exp_ovf_a) begin failures++;
            $display("FAIL rand_credit_fb[%0d] actual fb=%b ovf=%b required fb=%b ovf=%b", n, a_fb, a_ovf, exp_fb_a, exp_ovf_a); end
         checks++; if (b_count !== 4'(qb.size()) || b_valid !== (qb.size() != 0)) begin failures++;
            $display("FAIL rand_carloni_count[%0d] actual=%0d required=%0d", n, b_count, qb.size()); end
         if (qb.size() != 0) begin
            checks++; if (b_data !== qb[0]) begin failures++;
               $display("FAIL rand_carloni_data[%0d] actual=%h required=%h", n, b_data, qb[0]); end
         end
         checks++; if (b_fb !== exp_fb_b || b_ovf !== exp_ovf_b) begin failures++;
            $display("FAIL rand_carloni_fb[%0d] actual fb=%b ovf=%b required fb=%b ovf=%b", n, b_fb, b_ovf, exp_fb_b, exp_ovf_b); end
      end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_empty_single();
      test_full_push_pop();
      test_overflow();
      test_carloni();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
